// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller:
// stall-cause state encodings and default muldiv latencies.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MD_STALL   = 2'd2,
        FREEZE     = 2'd3
    } ctrl_state_t;

    localparam int MUL_LAT_DEF = 4;
    localparam int DIV_LAT_DEF = 32;

endpackage

// File: rtl/pipeline_stall_controller_muldiv_busy_counter.sv
// Muldiv occupancy counter: loads the op latency on start, counts down to 0.
// Ports: clk, reset, start, is_div in; md_busy, md_done out.
module muldiv_busy_counter
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W   = 6,
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic md_busy,
    output logic md_done
);

    logic [CNT_W-1:0] md_cnt;

    // The unit runs on its own: it keeps counting through pipeline freezes.
    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt <= '0;
        end else if (start) begin
            md_cnt <= is_div ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - 1'b1;
        end
    end

    assign md_busy = (md_cnt != '0);
    assign md_done = (md_cnt == CNT_W'(1)) && !reset;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Stall/freeze sequencer: merges load-use, HI/LO and memory-wait stalls
// into pipeline-register enables, ID/EX bubbles and muldiv scheduling.
module pipeline_stall_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_LAT     = MUL_LAT_DEF,
    parameter int DIV_LAT     = DIV_LAT_DEF,
    parameter int CNT_W       = 6,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   hz_stall,
    input  logic                   id_md_start,
    input  logic                   id_md_div,
    input  logic                   id_uses_hilo,
    input  logic                   mem_wait,
    output logic                   pc_enable,
    output logic                   if_id_enable,
    output logic                   id_ex_enable,
    output logic                   id_ex_nop,
    output logic                   ex_mem_enable,
    output logic                   mem_wb_enable,
    output logic                   md_go,
    output logic                   md_busy,
    output logic                   md_done,
    output logic [1:0]             ctrl_state,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    logic        md_hz;
    logic        front_stall;
    logic        sel_rst;
    logic        sel_frz;
    logic        sel_stl;
    logic        sel_run;
    ctrl_state_t state_q;
    ctrl_state_t state_d;

    // A second muldiv start while busy is a structural hazard too.
    assign md_hz       = md_busy & (id_uses_hilo | id_md_start);
    assign front_stall = hz_stall | md_hz;

    // Mutually exclusive selects, highest priority first.
    assign sel_rst = reset;
    assign sel_frz = !reset && mem_wait;
    assign sel_stl = !reset && !mem_wait && front_stall;
    assign sel_run = !reset && !mem_wait && !front_stall;

    always_comb begin
        pc_enable     = 1'b0;
        if_id_enable  = 1'b0;
        id_ex_enable  = 1'b0;
        id_ex_nop     = 1'b0;
        ex_mem_enable = 1'b0;
        mem_wb_enable = 1'b0;
        md_go         = 1'b0;
        state_d       = RUN;
        unique case (1'b1)
            sel_rst: begin
                id_ex_nop = 1'b1;
            end
            sel_frz: begin
                state_d = FREEZE;
            end
            sel_stl: begin
                id_ex_enable  = 1'b1;
                id_ex_nop     = 1'b1;
                ex_mem_enable = 1'b1;
                mem_wb_enable = 1'b1;
                state_d       = hz_stall ? LOAD_STALL : MD_STALL;
            end
            sel_run: begin
                pc_enable     = 1'b1;
                if_id_enable  = 1'b1;
                id_ex_enable  = 1'b1;
                ex_mem_enable = 1'b1;
                mem_wb_enable = 1'b1;
                md_go         = id_md_start;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            stall_cycles <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != RUN && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
        end
    end

    assign ctrl_state = state_q;

    muldiv_busy_counter #(
        .CNT_W   (CNT_W),
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_md_cnt (
        .clk     (clk),
        .reset   (reset),
        .start   (md_go),
        .is_div  (id_md_div),
        .md_busy (md_busy),
        .md_done (md_done)
    );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed testbench for pipeline_stall_controller, plus a narrow
// stall-counter instance to exercise saturation.
module tb_pipeline_stall_controller;

    logic clk = 1'b0;
    logic reset;
    logic hz_stall;
    logic id_md_start;
    logic id_md_div;
    logic id_uses_hilo;
    logic mem_wait;

    logic        pc_enable, if_id_enable, id_ex_enable, id_ex_nop;
    logic        ex_mem_enable, mem_wb_enable, md_go, md_busy, md_done;
    logic [1:0]  ctrl_state;
    logic [15:0] stall_cycles;

    logic        s_pc_enable, s_if_id_enable, s_id_ex_enable, s_id_ex_nop;
    logic        s_ex_mem_enable, s_mem_wb_enable, s_md_go, s_md_busy;
    logic        s_md_done;
    logic [1:0]  s_ctrl_state;
    logic [3:0]  s_stall_cycles;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_stall_controller dut (
        .clk           (clk),
        .reset         (reset),
        .hz_stall      (hz_stall),
        .id_md_start   (id_md_start),
        .id_md_div     (id_md_div),
        .id_uses_hilo  (id_uses_hilo),
        .mem_wait      (mem_wait),
        .pc_enable     (pc_enable),
        .if_id_enable  (if_id_enable),
        .id_ex_enable  (id_ex_enable),
        .id_ex_nop     (id_ex_nop),
        .ex_mem_enable (ex_mem_enable),
        .mem_wb_enable (mem_wb_enable),
        .md_go         (md_go),
        .md_busy       (md_busy),
        .md_done       (md_done),
        .ctrl_state    (ctrl_state),
        .stall_cycles  (stall_cycles)
    );

    pipeline_stall_controller #(.STALL_CNT_W(4)) dut_s (
        .clk           (clk),
        .reset         (reset),
        .hz_stall      (hz_stall),
        .id_md_start   (id_md_start),
        .id_md_div     (id_md_div),
        .id_uses_hilo  (id_uses_hilo),
        .mem_wait      (mem_wait),
        .pc_enable     (s_pc_enable),
        .if_id_enable  (s_if_id_enable),
        .id_ex_enable  (s_id_ex_enable),
        .id_ex_nop     (s_id_ex_nop),
        .ex_mem_enable (s_ex_mem_enable),
        .mem_wb_enable (s_mem_wb_enable),
        .md_go         (s_md_go),
        .md_busy       (s_md_busy),
        .md_done       (s_md_done),
        .ctrl_state    (s_ctrl_state),
        .stall_cycles  (s_stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Enables packed as {pc, if_id, id_ex, nop, ex_mem, mem_wb}.
    function automatic logic [31:0] ens();
        return {26'd0, pc_enable, if_id_enable, id_ex_enable,
                id_ex_nop, ex_mem_enable, mem_wb_enable};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        hz_stall     = 1'b0;
        id_md_start  = 1'b1;
        id_md_div    = 1'b0;
        id_uses_hilo = 1'b0;
        mem_wait     = 1'b0;
        #2;
        chk("rst_enables", ens(), 32'b000100);
        chk("rst_md_go", md_go, 0);
        tick();
        chk("rst_busy", md_busy, 0);
        chk("rst_state", ctrl_state, 0);
        chk("rst_stall_cnt", stall_cycles, 0);

        // load-use stall for one cycle
        reset       = 1'b0;
        id_md_start = 1'b0;
        hz_stall    = 1'b1;
        #1;
        chk("ls_enables", ens(), 32'b001111);
        tick();
        hz_stall = 1'b0;
        #1;
        chk("ls_state", ctrl_state, 1);
        chk("ls_cnt", stall_cycles, 1);
        chk("ls_run_en", ens(), 32'b111011);
        tick();
        chk("ls_state_run", ctrl_state, 0);

        // multiply, MFHI waits for completion
        id_md_start = 1'b1;
        id_md_div   = 1'b0;
        #1;
        chk("mul_go", md_go, 1);
        tick();
        id_md_start  = 1'b0;
        id_uses_hilo = 1'b1;
        for (int k = 4; k >= 1; k--) begin
            #1;
            chk("mul_busy", md_busy, 1);
            chk("mul_done", md_done, (k == 1));
            chk("mul_stall_en", ens(), 32'b001111);
            chk("mul_state", ctrl_state, (k == 4) ? 0 : 2);
            tick();
        end
        #1;
        chk("mul_idle", md_busy, 0);
        chk("mul_done_clr", md_done, 0);
        chk("mfhi_go_en", ens(), 32'b111011);
        chk("mul_state_end", ctrl_state, 2);
        chk("mul_cnt", stall_cycles, 5);
        id_uses_hilo = 1'b0;
        tick();

        // divide, second start 5 cycles later waits 27 cycles
        id_md_start = 1'b1;
        id_md_div   = 1'b1;
        #1;
        chk("div_go", md_go, 1);
        tick();
        id_md_start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("div_free_en", pc_enable, 1);
            tick();
        end
        id_md_start = 1'b1;
        for (int k = 27; k >= 1; k--) begin
            #1;
            chk("div2_hold", {31'd0, md_go}, 0);
            chk("div2_pc", pc_enable, 0);
            if (k == 1) chk("div_done", md_done, 1);
            tick();
        end
        #1;
        chk("div2_go", md_go, 1);
        chk("div2_pc_run", pc_enable, 1);
        chk("div2_cnt", stall_cycles, 32);
        tick();
        id_md_start = 1'b0;

        // memory freeze on top of load-use stall
        mem_wait = 1'b1;
        hz_stall = 1'b1;
        #1;
        chk("frz_enables", ens(), 32'b000000);
        chk("frz_go", md_go, 0);
        tick();
        mem_wait = 1'b0;
        #1;
        chk("frz_state", ctrl_state, 3);
        chk("frz_rel_en", ens(), 32'b001111);
        tick();
        hz_stall = 1'b0;
        #1;
        chk("frz_ls_state", ctrl_state, 1);
        chk("frz_cnt", stall_cycles, 34);
        // divider kept counting through the freeze: now at 30
        for (int k = 0; k < 20; k++) tick();

        // reset mid-divide at md_cnt = 10
        chk("md_mid_busy", md_busy, 1);
        reset    = 1'b1;
        hz_stall = 1'b1;
        #1;
        chk("rst2_enables", ens(), 32'b000100);
        chk("rst2_done", md_done, 0);
        tick();
        reset    = 1'b0;
        hz_stall = 1'b0;
        #1;
        chk("rst2_busy", md_busy, 0);
        chk("rst2_state", ctrl_state, 0);
        chk("rst2_cnt", stall_cycles, 0);
        chk("rst2_s_cnt", s_stall_cycles, 0);
        id_md_start = 1'b1;
        id_md_div   = 1'b0;
        #1;
        chk("rst2_go", md_go, 1);
        tick();
        id_md_start = 1'b0;

        // 20 stalls; LOAD_STALL wins over the concurrent HI/LO hazard
        hz_stall     = 1'b1;
        id_uses_hilo = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            #1;
            chk("sat_state", ctrl_state, 1);
            if (n == 15) chk("sat_s15", s_stall_cycles, 15);
        end
        chk("sat_s20", s_stall_cycles, 15);
        chk("sat_main", stall_cycles, 20);
        hz_stall     = 1'b0;
        id_uses_hilo = 1'b0;
        tick();
        #1;
        chk("sat_s_hold", s_stall_cycles, 15);
        chk("sat_end_state", ctrl_state, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
Central stall/freeze sequencer for the 5-stage MIPS pipeline. It merges three stall sources into one consistent set of pipeline-register enables and ID/EX bubble insertion:
- the load-use stall request from the hazard/forwarding unit;
- HI/LO hazards against the multi-cycle multiply/divide unit, which this block also schedules;
- data-memory wait.

It also keeps a registered stall-cause state and a saturating stall-cycle counter for debug.

Parameters:
MUL_LAT, 4, cycles a multiply occupies the muldiv unit (1..2^CNT_W-1)
DIV_LAT, 32, cycles a divide occupies the muldiv unit (1..2^CNT_W-1)
CNT_W, 6, width of the muldiv busy counter
STALL_CNT_W, 16, width of the stall-cycle counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
hz_stall  input  1  load-use stall request from hazard/forwarding unit (its nop_signal)
id_md_start  input  1  instruction in ID is MULT/MULTU/DIV/DIVU
id_md_div  input  1  qualifies id_md_start: 1=divide, 0=multiply
id_uses_hilo  input  1  instruction in ID reads HI/LO (MFHI/MFLO)
mem_wait  input  1  data memory not ready this cycle
pc_enable  output  1  PC and NPC load enable
if_id_enable  output  1  IF/ID register load enable
id_ex_enable  output  1  ID/EX register load enable
id_ex_nop  output  1  load zeroed control word into ID/EX (bubble)
ex_mem_enable  output  1  EX/MEM register load enable
mem_wb_enable  output  1  MEM/WB register load enable
md_go  output  1  qualified start pulse to the muldiv unit
md_busy  output  1  muldiv counter non-zero
md_done  output  1  muldiv result written to HI/LO at the end of this cycle
ctrl_state  output  2  registered cause of the previous cycle's stall
stall_cycles  output  STALL_CNT_W  saturating count of non-RUN cycles since reset

Behaviour:
- This block uses one clock, clk. Reset is synchronous and active-high. All registers update on the rising edge of clk.
- Registered state: ctrl_state, md_cnt[CNT_W-1:0], stall_cycles.
- Reset values: ctrl_state=RUN(2'd0), md_cnt=0, stall_cycles=0.
- While reset is high, combinational outputs are forced as follows: all five enables=0, id_ex_nop=1, md_go=0, md_done=0. md_busy=0 follows from md_cnt=0 after the edge.
- Derived terms, evaluated each cycle:
  - md_hz = md_busy & (id_uses_hilo | id_md_start). A second muldiv start while busy is also a hazard.
  - front_stall = hz_stall | md_hz.
- Control outputs are combinational in the same cycle (zero latency). Priority, highest first:
  - FREEZE (mem_wait=1): all five enables=0, id_ex_nop=0, md_go=0. No stage moves and no bubble is inserted. hz_stall and md_hz are ignored this cycle.
  - STALL (front_stall=1, mem_wait=0): pc_enable=0, if_id_enable=0, id_ex_enable=1, id_ex_nop=1, ex_mem_enable=1, mem_wb_enable=1, md_go=0.
  - RUN: all enables=1, id_ex_nop=0, md_go=id_md_start.
- Next-state encoding of ctrl_state:
  - FREEZE → 2'd3.
  - STALL with hz_stall=1 → LOAD_STALL 2'd1. When hz_stall and md_hz are both high, LOAD_STALL wins.
  - STALL with hz_stall=0 → MD_STALL 2'd2.
  - Otherwise RUN.
- No transition restrictions apply: any state may follow any state, driven purely by the inputs.
- md_cnt:
  - On md_go it loads DIV_LAT when id_md_div=1, else MUL_LAT.
  - Otherwise, when non-zero, it decrements every cycle, including FREEZE cycles; the unit runs independently of the pipeline.
  - md_busy = (md_cnt != 0).
  - md_done = (md_cnt == 1). It lasts exactly one cycle per operation.
  - md_go cannot occur while busy, because md_hz forces STALL.
- stall_cycles: increments on every cycle whose next ctrl_state != RUN, with reset=0, and saturates at all-ones.
- Boundary cases:
  - id_uses_hilo in the cycle md_cnt==1: md_busy=1, so the instruction stalls 1 cycle and then proceeds in the cycle md_cnt==0.
  - Reset mid-operation aborts the muldiv count. The next md_go is then accepted immediately.
  - mem_wait during a load-use stall holds the stalled instruction in ID. The stall re-evaluates when mem_wait drops.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - the ctrl_state encodings (RUN, LOAD_STALL, MD_STALL, FREEZE);
  - the MUL_LAT/DIV_LAT defaults.
- One natural sub-module, muldiv_busy_counter, owns md_cnt, md_busy and md_done, with inputs start, is_div and reset.
- The stall priority logic stays in the top module.

Test Plan:
1. hz_stall=1 for one cycle, mem_wait=0 → pc_enable=if_id_enable=0, id_ex_nop=1, ex_mem/mem_wb enables=1. ctrl_state=1 next cycle, then 0. stall_cycles=1.
2. id_md_start=1, id_md_div=0 in RUN → md_go=1. md_busy for 4 cycles. md_done high only in the 4th cycle after md_go. MFHI in ID during busy → stalls until md_cnt==0, with ctrl_state=2 for those cycles.
3. Divide (DIV_LAT=32), then a second id_md_start 5 cycles later → 27 stall cycles. The second md_go fires in the cycle md_cnt==0.
4. mem_wait=1 together with hz_stall=1 → all enables=0, id_ex_nop=0, ctrl_state=3. After mem_wait drops with hz_stall still 1 → STALL with ctrl_state=1.
5. reset pulsed at md_cnt=10 → next cycle md_busy=0, ctrl_state=0, stall_cycles=0. During reset: enables=0, id_ex_nop=1.
6. STALL_CNT_W=4 override, 20 consecutive stall cycles → stall_cycles saturates at 15.
